uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
8N1 UART receiver, the receive-side counterpart of the existing uart_tx. It synchronises the asynchronous rx line and detects the start bit. It recovers one byte per frame using mid-bit majority-vote sampling and presents it with a single-cycle valid pulse. It also reports framing errors and line breaks. It sits between the board UART pin and the command decoder in top, and shares main_clk (50 MHz in simulation).

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal range 16..65535
CNT_W, 16, width of the bit-period counter; must hold CLKS_PER_BIT-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial input, idle high
data  output  8  last correctly received byte, LSB first on the line
valid  output  1  one-cycle pulse when data updates
frame_err  output  1  one-cycle pulse when the stop bit samples low
busy  output  1  high from start-bit detection until return to IDLE
break_det  output  1  level, high while in BRK_WAIT

Behaviour:
- Reset values: data=8'h00, valid=0, frame_err=0, busy=0, break_det=0, state=IDLE, counters=0, synchroniser and vote registers=1.
- Reset applied mid-frame aborts the frame immediately, with no valid and no frame_err pulse.
- Input path: rx passes through a 2-FF synchroniser (rx_s), then a 3-bit history shift register. The bit value is the majority of the 3 most recent rx_s samples, so one-cycle glitches are rejected.
- Bit counter cnt counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
- IDLE: busy=0. When rx_s==0, go to START with cnt=0 and busy=1.
- START: when cnt==CLKS_PER_BIT/2-1 (integer division), evaluate the vote.
  - Vote 1: false start, go to IDLE, no pulse.
  - Vote 0: go to DATA with bit_idx=0 and cnt=0.
- DATA: when cnt==CLKS_PER_BIT-1, shift the vote into shreg[7] (right shift, LSB first) and increment bit_idx. After the shift with bit_idx==7, go to STOP.
- STOP: when cnt==CLKS_PER_BIT-1, evaluate the vote.
  - Vote 1: data<=shreg and valid=1 for exactly one cycle, then go to IDLE. The return happens at stop mid-bit, which allows back-to-back frames with a 1-stop-bit gap.
  - Vote 0: frame_err=1 for one cycle, data unchanged, go to BRK_WAIT.
- BRK_WAIT: break_det=1, busy=1. Stay until rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering start detection.
- valid and frame_err are never high in the same cycle.
- Latency: valid rises 9.5*CLKS_PER_BIT + 3 ±2 cycles after the rx start-bit falling edge.
- data holds its value until the next good frame; there is no consumer handshake and no overrun flag. Downstream must capture on valid.
- Tolerance: correct reception with a transmitter clock offset of up to ±3% versus CLKS_PER_BIT.

Test Plan:
1. uart_tx sends 8'h40, then 8'h41, then 8'h42 (CLKS_PER_BIT=434, 50 MHz).
   Required: three valid pulses, each exactly 1 cycle wide, with data=40,41,42 in order. frame_err stays 0.
2. Back-to-back frames 8'h55, 8'hAA with 1 stop bit and no idle gap.
   Required: both bytes received, and valid pulses spaced 10*434 ±2 cycles apart.
3. Frame 8'h3C with the stop bit forced low, then rx held low for 20 bit times, then released.
   Required: frame_err pulses once and data stays at its previous value. break_det stays high until rx returns high, then IDLE. A following frame 8'h12 gives valid with data=12.
4. A 100 ns low glitch on idle rx, and separately a 1-cycle inverted glitch at the midpoint of data bit 3 of frame 8'hF0.
   Required: no valid and no busy stuck from the idle glitch. The frame gives data=F0, showing the majority vote filtered the glitch.
5. reset asserted for 2 cycles in the middle of data bit 4 of frame 8'h99.
   Required: all outputs are at reset values on the cycle after reset. No valid for the aborted frame. The next full frame 8'h66 gives data=66.
6. Transmitter bit period 421 and then 447 cycles (±3%), sending 8'hA5.
   Required: data=A5 with valid in both cases.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the UART receiver
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic       break_det;

  modport master (
    input  rx,
    output data, valid, frame_err, busy, break_det
  );

  modport slave (
    output rx,
    input  data, valid, frame_err, busy, break_det
  );
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with mid-bit majority-vote sampling
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input logic       clk,
  input logic       reset,
  uart_rx_if.master bus
);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       data_q, data_n;
  logic             valid_q, valid_n;
  logic             frame_err_q, frame_err_n;
  logic             rx_meta, rx_s;
  logic [2:0]       hist;
  logic             vote;

  // Synchroniser and history idle high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      hist    <= 3'b111;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      hist    <= {hist[1:0], rx_s};
    end
  end

  assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      data_q      <= data_n;
      valid_q     <= valid_n;
      frame_err_q <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    data_n      = data_q;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n     = '0;
          bit_idx_n = 3'd0;
          state_n   = vote ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n     = '0;
          shreg_n   = {vote, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // Leaving at stop mid-bit leaves half a bit to catch a back-to-back start.
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (vote) begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = BRK_WAIT;
          end
        end
      end
      BRK_WAIT: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != IDLE);
  assign bus.break_det = (state == BRK_WAIT);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - randomized self-checking bench for uart_rx_core
module tb_uart_rx_core;
  localparam int CPB = 434;

  logic clk;
  logic reset;
  uart_rx_if u_if ();

  uart_rx_core #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wide_cnt = 0, both_cnt = 0, fe_cnt = 0, exp_fe = 0;
  int last_start = 0;
  logic valid_d = 1'b0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int vt_q[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.valid) begin
      got_q.push_back(u_if.data);
      vt_q.push_back(cyc);
    end
    if (u_if.valid && valid_d) wide_cnt++;
    if (u_if.frame_err) fe_cnt++;
    if (u_if.valid && u_if.frame_err) both_cnt++;
    valid_d = u_if.valid;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference rule: good stop bit yields the byte, low stop bit yields a
  // framing error, an aborted frame yields nothing.
  task automatic send_frame(input logic [7:0] b, input int per, input bit stop_low,
                            input int glitch_bit, input int abort_bit);
    u_if.rx = 1'b0;
    last_start = cyc;
    hold(per);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      if (i == abort_bit) begin
        hold(per / 2);
        return;
      end
      if (i == glitch_bit) begin
        hold(per / 2);
        u_if.rx = ~b[i];
        hold(1);
        u_if.rx = b[i];
        hold(per - per / 2 - 1);
      end else begin
        hold(per);
      end
    end
    u_if.rx = ~stop_low;
    if (stop_low) exp_fe++;
    else begin
      exp_q.push_back(b);
      last_good = b;
    end
    hold(per);
  endtask

  task automatic drain(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_eq(tag, int'(got_q.pop_front()), int'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_data"},  int'(u_if.data), int'(last_good));
    check_eq({tag, "_valid"}, int'(u_if.valid), 0);
    check_eq({tag, "_ferr"},  int'(u_if.frame_err), 0);
    check_eq({tag, "_busy"},  int'(u_if.busy), 0);
    check_eq({tag, "_brk"},   int'(u_if.break_det), 0);
  endtask

  initial begin
    logic [7:0] rb;
    int per, gap, diff;
    u_if.rx = 1'b1;
    reset = 1'b1;
    hold(3);
    @(negedge clk);
    check_idle_outputs("reset");
    hold(1);
    reset = 1'b0;
    hold(20);

    // Sequential bytes, pulse width and latency
    vt_q.delete();
    send_frame(8'h40, CPB, 0, -1, -1);
    diff = vt_q.size() > 0 ? vt_q[0] - last_start : -1;
    check_eq("latency_ok", int'(diff >= 4124 && diff <= 4128), 1);
    hold(100);
    send_frame(8'h41, CPB, 0, -1, -1);
    hold(100);
    send_frame(8'h42, CPB, 0, -1, -1);
    hold(100);
    drain("seq");
    check_eq("seq_ferr", fe_cnt, 0);
    check_eq("seq_width", wide_cnt, 0);

    // Back-to-back with a single stop bit
    vt_q.delete();
    send_frame(8'h55, CPB, 0, -1, -1);
    send_frame(8'hAA, CPB, 0, -1, -1);
    hold(100);
    check_eq("b2b_pulses", vt_q.size(), 2);
    diff = vt_q.size() == 2 ? vt_q[1] - vt_q[0] : 0;
    check_eq("b2b_gap_ok", int'(diff >= 10 * CPB - 2 && diff <= 10 * CPB + 2), 1);
    drain("b2b");

    // Framing error followed by a held break
    send_frame(8'h3C, CPB, 1, -1, -1);
    hold(10 * CPB);
    check_eq("brk_ferr_once", fe_cnt, exp_fe);
    check_eq("brk_det", int'(u_if.break_det), 1);
    check_eq("brk_busy", int'(u_if.busy), 1);
    check_eq("brk_data", int'(u_if.data), int'(last_good));
    hold(10 * CPB);
    u_if.rx = 1'b1;
    hold(8);
    check_idle_outputs("brk_rel");
    send_frame(8'h12, CPB, 0, -1, -1);
    hold(100);
    drain("brk_next");

    // Idle glitch, then a glitch inside data bit 3
    u_if.rx = 1'b0;
    hold(5);
    u_if.rx = 1'b1;
    hold(300);
    check_idle_outputs("idle_glitch");
    drain("idle_glitch");
    send_frame(8'hF0, CPB, 0, 3, -1);
    hold(100);
    drain("bit_glitch");

    // Reset in the middle of data bit 4
    send_frame(8'h99, CPB, 0, -1, 4);
    reset = 1'b1;
    hold(2);
    reset = 1'b0;
    last_good = 8'h00;
    @(negedge clk);
    check_idle_outputs("midreset");
    u_if.rx = 1'b1;
    hold(2 * CPB);
    drain("midreset");
    send_frame(8'h66, CPB, 0, -1, -1);
    hold(100);
    drain("after_reset");

    // Transmitter clock offsets
    send_frame(8'hA5, 421, 0, -1, -1);
    hold(100);
    send_frame(8'hA5, 447, 0, -1, -1);
    hold(100);
    drain("offset");

    // Random bytes, periods and gaps
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom);
      per = $urandom_range(447, 421);
      gap = $urandom_range(200, 0);
      send_frame(rb, per, 0, -1, -1);
      if (gap > 0) hold(gap);
    end
    hold(100);
    drain("rand");

    check_eq("final_ferr", fe_cnt, exp_fe);
    check_eq("final_width", wide_cnt, 0);
    check_eq("final_exclusive", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
